argmax_collector: RTL
=====================

ARGMAX_COLLECTOR -- requirements
Module: argmax_collector

Interface
REQ-001 SHALL have parameter width, default 10, bit width of one signed two's-complement activation.
REQ-002 SHALL have parameter Z, default 1, output neurons presented per clk (power of 2, divides N_OUT).
REQ-003 SHALL have parameter N_OUT, default 4, total output neurons (power of 2, >=2).
REQ-004 SHALL have parameter SKIP, default 2, garbage clks at start of each block cycle; localparam CPC = N_OUT/Z + SKIP.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 cycle_clk  in  1  one-clk pulse, synchronous to clk, marking block-cycle boundary.
REQ-008 cycle_index  in  $clog2(CPC)  clk position within block cycle, 0 on the clk cycle_clk is high.
REQ-009 act_in  in  width*Z  Z activations, lane k at [width*k +: width].
REQ-010 ans_in  in  Z  ideal-output bits for the same Z neurons.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 out_valid  out  1  result held on outputs.
REQ-013 actL_alln  out  N_OUT  one-hot winning neuron.
REQ-014 max_pos  out  $clog2(N_OUT)  winning neuron index.
REQ-015 max_val  out  width  winning activation.
REQ-016 correct  out  1  max_pos equals ideal-output position.
REQ-017 dropped  out  1  sticky: an unaccepted result was overwritten.

Function
REQ-018 Neuron index of lane k at clk with cycle_index=c (c>=SKIP) SHALL be Z*(c-SKIP)+k; clks with c<SKIP SHALL be ignored.
REQ-019 Local max across Z lanes SHALL use signed compare; ties SHALL select lowest lane.
REQ-020 Stored max SHALL be replaced only when local max is strictly greater; ties keep earlier (lower) index.
REQ-021 Ideal position SHALL be captured as index of first set ans_in bit in the block; ans_seen flag set; later set bits ignored.
REQ-022 On clk with cycle_clk=1: if primed (>=1 clk with cycle_index>=SKIP since last boundary or reset), stored result SHALL load output registers next edge, out_valid=1; stored max SHALL reset to 1'b1 followed by zeros (most negative), stored pos 0, ans_seen 0, primed 0.
REQ-023 Data on the cycle_clk clk itself SHALL NOT be accumulated (cycle_index=0<SKIP).
REQ-024 correct SHALL be 1 only if ans_seen and ideal position equals max_pos.
REQ-025 Latency: result visible one clk after the cycle_clk edge.
REQ-026 Handshake: out_valid && out_ready at an edge SHALL clear out_valid unless a new result loads in the same edge, in which case out_valid stays 1 and dropped unchanged.
REQ-027 New result loading while out_valid=1 and out_ready=0 SHALL overwrite outputs and set dropped=1.
REQ-028 Outputs SHALL stay stable while out_valid=1 and no new result loads.
REQ-029 cycle_clk without prior priming SHALL produce no result and SHALL NOT change outputs.

Reset
REQ-030 reset=0 at a clk edge SHALL clear out_valid, actL_alln, max_pos, max_val, correct, dropped to 0, stored max to most negative, primed and ans_seen to 0.
REQ-031 Reset asserted mid-block SHALL discard partial accumulation; first boundary after release yields no result unless primed.

Configuration
REQ-032 Macro ARGMAX_ACC_COUNT_EN defined: SHALL add outputs total_cnt[15:0] and correct_cnt[15:0], incremented (saturating at 16'hFFFF) on each result load, correct_cnt only when correct-to-be is 1; cleared by reset.
REQ-033 Macro undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-034 Defaults; lanes per c=2..5: 10'sd5,-3,10'sd100,10'sd7; ans_in set at c=4 -> after next cycle_clk: max_pos=2, actL_alln=4'b0100, max_val=100, correct=1, out_valid=1.
REQ-035 Tie: activations 9,9,1,0 -> max_pos=0; Z=2, N_OUT=8 lanes {3,20},{20,1},... -> max_pos=1.
REQ-036 All activations 10'h200 (most negative) -> max_pos=0, max_val=10'h200.
REQ-037 Two results with out_ready=0 -> second overwrites first, dropped=1; out_ready=1 same edge as load -> out_valid stays 1, dropped=0.
REQ-038 Reset=0 at c=3 of a block -> outputs 0; next cycle_clk with no primed clk -> out_valid stays 0.
REQ-039 ARGMAX_ACC_COUNT_EN: 3 blocks, 2 correct -> total_cnt=3, correct_cnt=2; preload near 16'hFFFF -> saturates.

Source files
------------

// File: rtl/argmax_collector_if.sv
// ---------------------------------------------------------------------------
// argmax_collector_if
//
// Groups the block-cycle input bus and the result/handshake outputs of
// argmax_collector. Clock and reset stay plain ports on the module.
//
// Optional feature macro: ARGMAX_ACC_COUNT_EN adds total_cnt / correct_cnt.
//
// Signals:
//   cycle_clk    one-clk pulse marking a block-cycle boundary
//   cycle_index  clk position inside the block cycle (0 on the cycle_clk clk)
//   act_in       Z signed activations, lane k at [width*k +: width]
//   ans_in       ideal-output bits for the same Z neurons
//   out_ready    consumer accepts the held result
//   out_valid    result is held on the outputs
//   actL_alln    one-hot winning neuron
//   max_pos      winning neuron index
//   max_val      winning activation
//   correct      max_pos matches the ideal-output position
//   dropped      sticky: an unaccepted result was overwritten
//   total_cnt    (ARGMAX_ACC_COUNT_EN) saturating count of results
//   correct_cnt  (ARGMAX_ACC_COUNT_EN) saturating count of correct results
//
// Modports: master = producer/consumer side (testbench), slave = collector.
// ---------------------------------------------------------------------------
interface argmax_collector_if #(
    parameter int width = 10,
    parameter int Z     = 1,
    parameter int N_OUT = 4,
    parameter int SKIP  = 2
);
    localparam int CPC = N_OUT / Z + SKIP;
    localparam int IW  = $clog2(CPC);
    localparam int PW  = $clog2(N_OUT);

    logic                  cycle_clk;
    logic [IW-1:0]         cycle_index;
    logic [width*Z-1:0]    act_in;
    logic [Z-1:0]          ans_in;
    logic                  out_ready;
    logic                  out_valid;
    logic [N_OUT-1:0]      actL_alln;
    logic [PW-1:0]         max_pos;
    logic [width-1:0]      max_val;
    logic                  correct;
    logic                  dropped;
`ifdef ARGMAX_ACC_COUNT_EN
    logic [15:0]           total_cnt;
    logic [15:0]           correct_cnt;

    modport master (
        output cycle_clk, cycle_index, act_in, ans_in, out_ready,
        input  out_valid, actL_alln, max_pos, max_val, correct, dropped,
               total_cnt, correct_cnt
    );

    modport slave (
        input  cycle_clk, cycle_index, act_in, ans_in, out_ready,
        output out_valid, actL_alln, max_pos, max_val, correct, dropped,
               total_cnt, correct_cnt
    );
`else
    modport master (
        output cycle_clk, cycle_index, act_in, ans_in, out_ready,
        input  out_valid, actL_alln, max_pos, max_val, correct, dropped
    );

    modport slave (
        input  cycle_clk, cycle_index, act_in, ans_in, out_ready,
        output out_valid, actL_alln, max_pos, max_val, correct, dropped
    );
`endif
endinterface

// File: rtl/argmax_collector.sv
// ---------------------------------------------------------------------------
// argmax_collector
//
// Streams N_OUT signed activations, Z per clk, over one block cycle and
// reports the arg-max neuron at each block boundary (cycle_clk). The first
// SKIP clks of every block carry garbage and are ignored. Ties resolve to the
// lowest neuron index. The position of the first set ideal-output bit is
// compared with the winner to produce 'correct'. Results are held under a
// valid/ready handshake; a result overwritten before acceptance sets the
// sticky 'dropped' flag.
//
// Optional feature macro: ARGMAX_ACC_COUNT_EN -- adds saturating 16-bit
// total_cnt / correct_cnt result counters on the interface.
//
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   synchronous, active-low reset
//   bus    slave modport of argmax_collector_if (block bus + result outputs)
// ---------------------------------------------------------------------------
module argmax_collector #(
    parameter int width = 10,
    parameter int Z     = 1,
    parameter int N_OUT = 4,
    parameter int SKIP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    argmax_collector_if.slave bus
);
    localparam int PW = $clog2(N_OUT);
    localparam int LW = (Z > 1) ? $clog2(Z) : 1;
    localparam logic [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

    // ---------------- per-clk lane evaluation ----------------
    logic signed [width-1:0] w_lane [Z];
    logic signed [width-1:0] w_loc_val;
    logic [LW-1:0]           w_loc_lane;
    logic                    w_ans_hit;
    logic [LW-1:0]           w_ans_lane;
    logic [PW-1:0]           w_base;
    logic [PW-1:0]           w_loc_pos;
    logic [PW-1:0]           w_ans_pos;
    logic                    w_active;

    always_comb begin
        for (int unsigned k = 0; k < Z; k++) begin
            w_lane[k] = bus.act_in[width*k +: width];
        end
    end

    // Strict '>' while scanning upward keeps the lowest lane on ties.
    always_comb begin
        w_loc_val  = w_lane[0];
        w_loc_lane = '0;
        for (int unsigned k = 1; k < Z; k++) begin
            if (w_lane[k] > w_loc_val) begin
                w_loc_val  = w_lane[k];
                w_loc_lane = k[LW-1:0];
            end
        end
    end

    always_comb begin
        w_ans_hit  = 1'b0;
        w_ans_lane = '0;
        for (int unsigned k = 0; k < Z; k++) begin
            if (bus.ans_in[k] && !w_ans_hit) begin
                w_ans_hit  = 1'b1;
                w_ans_lane = k[LW-1:0];
            end
        end
    end

    // Neuron index = Z*(c-SKIP)+lane; arithmetic is modulo 2^PW, which is
    // exact because every valid index fits in PW bits.
    assign w_base    = (PW'(bus.cycle_index) - PW'(SKIP)) * PW'(Z);
    assign w_loc_pos = w_base + PW'(w_loc_lane);
    assign w_ans_pos = w_base + PW'(w_ans_lane);

    // The boundary clk itself never contributes data.
    assign w_active  = !bus.cycle_clk && (32'(bus.cycle_index) >= 32'(SKIP));

    // ---------------- block accumulator ----------------
    logic signed [width-1:0] r_acc_val;
    logic [PW-1:0]           r_acc_pos;
    logic [PW-1:0]           r_ans_pos;
    logic                    r_ans_seen;
    logic                    r_primed;

    always_ff @(posedge clk) begin
        if (!reset || bus.cycle_clk) begin
            r_acc_val  <= MOST_NEG;
            r_acc_pos  <= '0;
            r_ans_pos  <= '0;
            r_ans_seen <= 1'b0;
            r_primed   <= 1'b0;
        end else if (w_active) begin
            r_primed <= 1'b1;
            if (w_loc_val > r_acc_val) begin
                r_acc_val <= w_loc_val;
                r_acc_pos <= w_loc_pos;
            end
            if (w_ans_hit && !r_ans_seen) begin
                r_ans_seen <= 1'b1;
                r_ans_pos  <= w_ans_pos;
            end
        end
    end

    // ---------------- result registers / handshake ----------------
    logic                    w_load;
    logic                    w_correct_new;
    logic [N_OUT-1:0]        w_onehot;

    logic                    r_out_valid;
    logic [N_OUT-1:0]        r_actL_alln;
    logic [PW-1:0]           r_max_pos;
    logic [width-1:0]        r_max_val;
    logic                    r_correct;
    logic                    r_dropped;

    assign w_load        = bus.cycle_clk && r_primed;
    assign w_correct_new = r_ans_seen && (r_ans_pos == r_acc_pos);

    always_comb begin
        w_onehot            = '0;
        w_onehot[r_acc_pos] = 1'b1;
    end

    // A load always wins over acceptance: valid stays high and only an
    // unaccepted old result marks the drop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_actL_alln <= '0;
            r_max_pos   <= '0;
            r_max_val   <= '0;
            r_correct   <= 1'b0;
            r_dropped   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_actL_alln <= w_onehot;
            r_max_pos   <= r_acc_pos;
            r_max_val   <= r_acc_val;
            r_correct   <= w_correct_new;
            if (r_out_valid && !bus.out_ready) begin
                r_dropped <= 1'b1;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.actL_alln = r_actL_alln;
    assign bus.max_pos   = r_max_pos;
    assign bus.max_val   = r_max_val;
    assign bus.correct   = r_correct;
    assign bus.dropped   = r_dropped;

`ifdef ARGMAX_ACC_COUNT_EN
    // ---------------- saturating result counters ----------------
    logic [15:0] r_total_cnt;
    logic [15:0] r_correct_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_total_cnt   <= '0;
            r_correct_cnt <= '0;
        end else if (w_load) begin
            if (r_total_cnt != 16'hFFFF) begin
                r_total_cnt <= r_total_cnt + 16'd1;
            end
            if (w_correct_new && (r_correct_cnt != 16'hFFFF)) begin
                r_correct_cnt <= r_correct_cnt + 16'd1;
            end
        end
    end

    assign bus.total_cnt   = r_total_cnt;
    assign bus.correct_cnt = r_correct_cnt;
`endif

endmodule
